mem_access_unit: RTL and testbench

MEM-stage data-memory access controller: takes the load/store request held in the EX/MEM register, drives a req/ack memory bus, stalls the pipeline until the access completes, and presents the aligned, extended load data to the MEM/WB pipeline register. It is the producer side of MEM/WB: its `read_data_out` feeds MEM/WB `read_data_in`. Its `wb_suppress_out` gates `RegWrite_in` so that stall or fault cycles enter write-back as bubbles.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/mem_access_unit_if.sv | 29 ++
 rtl/mem_access_unit_load_extend.sv | 29 ++
 rtl/mem_access_unit.sv | 162 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the MEM stage.
// Access sizes, MEM FSM states and fault causes.
package pipe_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mem_state_t;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_BUSERR   = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory req/ack bus between the MEM stage
// (master) and the memory (slave).
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [3:0]        bus_be;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_err;

  modport master (
    output bus_req, bus_we, bus_addr,
    output bus_wdata, bus_be,
    input  bus_ack, bus_rdata, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr,
    input  bus_wdata, bus_be,
    output bus_ack, bus_rdata, bus_err
  );

endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Load lane select and sign/zero extension
// of a 32-bit bus word.
module load_extend
  import pipe_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  // Pick the addressed lane, then extend by size/sign.
  always_comb begin
    b = rdata[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    result = rdata;
    unique case (funct3)
      F3_B:    result = {{24{b[7]}}, b};
      F3_BU:   result = {24'd0, b};
      F3_H:    result = {{16{h[15]}}, h};
      F3_HU:   result = {16'd0, h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller:
// classifies, runs the req/ack bus, stalls, extends.
module mem_access_unit
  import pipe_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic [2:0]        funct3_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              stall_out,
  output logic              wb_suppress_out,
  output logic [DATA_W-1:0] read_data_out,
  output logic              fault_out,
  output logic [1:0]        fault_cause_out,
  mem_access_unit_if.master bus
);

  mem_state_t state_q, state_d;

  logic              access;
  logic              illegal;
  logic              misalign;
  logic              legal;
  logic              is_half;
  logic              is_word;
  logic [3:0]        be_d;
  logic [DATA_W-1:0] wdata_d;
  logic              err_q;
  logic              load_q;
  logic [2:0]        f3_q;
  logic [1:0]        lo_q;
  logic [DATA_W-1:0] ext;

  load_extend u_ext (
    .rdata   (bus.bus_rdata),
    .addr_lo (lo_q),
    .funct3  (f3_q),
    .result  (ext)
  );

  // Classify the request held in EX/MEM.
  always_comb begin
    access  = MemRead_in | MemWrite_in;
    is_half = funct3_in[1:0] == 2'b01;
    is_word = funct3_in[1:0] == 2'b10;
    illegal = (MemRead_in & MemWrite_in)
            | (MemWrite_in
               & !(funct3_in inside {F3_B, F3_H, F3_W}))
            | (MemRead_in
               & (funct3_in inside {3'b011, 3'b110, 3'b111}));
    misalign = (is_half & addr_in[0])
             | (is_word & (|addr_in[1:0]));
  end

  // Byte enables and lane-replicated store data.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = wdata_in;
    unique case (1'b1)
      funct3_in[1:0] == 2'b00: begin
        wdata_d = {4{wdata_in[7:0]}};
        if (MemWrite_in) be_d = 4'b0001 << addr_in[1:0];
      end
      is_half: begin
        wdata_d = {2{wdata_in[15:0]}};
        if (MemWrite_in) be_d = 4'b0011 << addr_in[1:0];
      end
      default: ;
    endcase
  end

  // Next state and pipeline control; all drop with reset.
  always_comb begin
    state_d         = state_q;
    legal           = 1'b0;
    stall_out       = 1'b0;
    fault_out       = 1'b0;
    fault_cause_out = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          if (illegal) begin
            fault_out       = 1'b1;
            fault_cause_out = CAUSE_ILLEGAL;
          end else if (misalign) begin
            fault_out       = 1'b1;
            fault_cause_out = CAUSE_MISALIGN;
          end else begin
            legal     = 1'b1;
            stall_out = 1'b1;
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        stall_out = 1'b1;
        if (bus.bus_ack) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (err_q) begin
          fault_out       = 1'b1;
          fault_cause_out = CAUSE_BUSERR;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst) begin
      legal           = 1'b0;
      stall_out       = 1'b0;
      fault_out       = 1'b0;
      fault_cause_out = 2'b00;
    end
    wb_suppress_out = stall_out | fault_out;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Bus request, captured request info and load result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.bus_be    <= 4'b0000;
      err_q         <= 1'b0;
      load_q        <= 1'b0;
      f3_q          <= 3'b000;
      lo_q          <= 2'b00;
      read_data_out <= '0;
    end else begin
      if (legal) begin
        bus.bus_req   <= 1'b1;
        bus.bus_we    <= MemWrite_in;
        bus.bus_addr  <= {addr_in[ADDR_W-1:2], 2'b00};
        bus.bus_wdata <= wdata_d;
        bus.bus_be    <= be_d;
        load_q        <= MemRead_in;
        f3_q          <= funct3_in;
        lo_q          <= addr_in[1:0];
      end
      if (state_q == BUSY && bus.bus_ack) begin
        bus.bus_req <= 1'b0;
        err_q       <= bus.bus_err;
        if (load_q && !bus.bus_err)
          read_data_out <= ext;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit:
// transaction model, per-cycle compare, directed pins.
module tb_mem_access_unit;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [2:0]  f3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall, wbs, fault;
  logic [31:0] rdo;
  logic [1:0]  cause;

  mem_access_unit_if bus_if ();

  mem_access_unit dut (
    .clk             (clk),
    .rst             (rst),
    .MemRead_in      (mem_rd),
    .MemWrite_in     (mem_wr),
    .funct3_in       (f3),
    .addr_in         (addr),
    .wdata_in        (wdata),
    .stall_out       (stall),
    .wb_suppress_out (wbs),
    .read_data_out   (rdo),
    .fault_out       (fault),
    .fault_cause_out (cause),
    .bus             (bus_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic        e_valid = 1'b0;
  logic        e_stall, e_wbs, e_fault, e_req, e_we;
  logic [1:0]  e_cause;
  logic [31:0] e_addr, e_wdata, m_rd;
  logic [3:0]  e_be;

  int          n_stall, n_fault, n_req;
  logic [1:0]  last_cause;
  logic        last_we;
  logic [3:0]  last_be;
  logic [31:0] last_addr, last_wdata;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %h want %h",
               name, $time, act, exp);
    end
  endtask

  // Model: 0 = legal, otherwise the fault cause.
  function automatic logic [1:0] m_class(
      input logic rd, input logic wr,
      input logic [2:0] f, input logic [31:0] a);
    int nb;
    if (rd && wr) return 2'd3;
    if (wr && f > 3'd2) return 2'd3;
    if (rd && (f == 3'd3 || f > 3'd5)) return 2'd3;
    nb = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    if ((a % nb) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] m_load(
      input logic [2:0] f, input logic [31:0] a,
      input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * (a % 4));
    case (f)
      3'd0: return s[7] ? 32'(s[7:0]) - 32'd256
                        : 32'(s[7:0]);
      3'd4: return 32'(s[7:0]);
      3'd1: return s[15] ? 32'(s[15:0]) - 32'd65536
                         : 32'(s[15:0]);
      3'd5: return 32'(s[15:0]);
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] m_be(
      input logic wr, input logic [2:0] f,
      input logic [31:0] a);
    if (!wr) return 4'hf;
    if (f == 3'd0) return 4'(1 << (a % 4));
    if (f == 3'd1) return 4'(3 << (a % 4));
    return 4'hf;
  endfunction

  function automatic logic [31:0] m_wd(
      input logic [2:0] f, input logic [31:0] d);
    if (f[1:0] == 2'd0) return 32'(d[7:0]) * 32'h01010101;
    if (f[1:0] == 2'd1) return 32'(d[15:0]) * 32'h00010001;
    return d;
  endfunction

  // Compare DUT outputs against the model each cycle.
  always @(negedge clk) begin
    if (e_valid) begin
      check("stall", stall, e_stall);
      check("wb_suppress", wbs, e_wbs);
      check("fault", fault, e_fault);
      if (e_fault) check("cause", cause, e_cause);
      check("bus_req", bus_if.bus_req, e_req);
      if (e_req) begin
        check("bus_we", bus_if.bus_we, e_we);
        check("bus_addr", bus_if.bus_addr, e_addr);
        check("bus_be", bus_if.bus_be, e_be);
        check("bus_wdata", bus_if.bus_wdata, e_wdata);
      end
      check("read_data", rdo, m_rd);
      if (stall) n_stall++;
      if (fault) begin
        n_fault++;
        last_cause = cause;
      end
      if (bus_if.bus_req) begin
        n_req++;
        last_we    = bus_if.bus_we;
        last_be    = bus_if.bus_be;
        last_addr  = bus_if.bus_addr;
        last_wdata = bus_if.bus_wdata;
      end
    end
  end

  task automatic junk_bus();
    bus_if.bus_ack   = 1'($urandom);
    bus_if.bus_rdata = $urandom;
    bus_if.bus_err   = 1'($urandom);
  endtask

  task automatic set_exp(input logic s, input logic fl,
                         input logic [1:0] c,
                         input logic r);
    e_stall = s;
    e_fault = fl;
    e_cause = c;
    e_wbs   = s | fl;
    e_req   = r;
  endtask

  task automatic clr_counts();
    n_stall = 0;
    n_fault = 0;
    n_req   = 0;
  endtask

  // One instruction from EX/MEM, held until it leaves.
  task automatic run(input logic rd, input logic wr,
                     input logic [2:0] f,
                     input logic [31:0] a,
                     input logic [31:0] wd,
                     input logic [31:0] rdat,
                     input logic er, input int w);
    logic [1:0] c;
    mem_rd = rd;
    mem_wr = wr;
    f3     = f;
    addr   = a;
    wdata  = wd;
    c = m_class(rd, wr, f, a);
    if (!(rd || wr) || c != 2'd0) begin
      set_exp(1'b0, rd | wr, c, 1'b0);
      junk_bus();
      @(posedge clk) #1;
    end else begin
      set_exp(1'b1, 1'b0, 2'd0, 1'b0);
      junk_bus();
      @(posedge clk) #1;
      e_we    = wr;
      e_addr  = a & 32'hffff_fffc;
      e_be    = m_be(wr, f, a);
      e_wdata = m_wd(f, wd);
      for (int i = 0; i <= w; i++) begin
        set_exp(1'b1, 1'b0, 2'd0, 1'b1);
        bus_if.bus_ack   = (i == w);
        bus_if.bus_rdata = (i == w) ? rdat : $urandom;
        bus_if.bus_err   = (i == w) ? er : 1'($urandom);
        @(posedge clk) #1;
      end
      if (rd && !er) m_rd = m_load(f, a, rdat);
      set_exp(1'b0, er, 2'd2, 1'b0);
      junk_bus();
      @(posedge clk) #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic rd, wr, er;
    logic [2:0] f;
    logic [31:0] a;
    int r;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = '0;
    bus_if.bus_err   = 1'b0;
    m_rd = '0;
    clr_counts();
    #2;
    check("rst_req", bus_if.bus_req, 0);
    check("rst_stall", stall, 0);
    check("rst_rdata", rdo, 0);
    check("rst_addr", bus_if.bus_addr, 0);
    check("rst_be", bus_if.bus_be, 0);
    @(posedge clk) #1;
    rst = 1'b1;
    e_valid = 1'b1;

    clr_counts();
    run(1, 0, F3_W, 32'h104, 0, 32'hDEADBEEF, 0, 0);
    check("lw_stalls", n_stall, 2);
    check("lw_be", last_be, 4'b1111);
    check("lw_addr", last_addr, 32'h104);
    check("lw_data", rdo, 32'hDEADBEEF);

    run(1, 0, F3_B, 32'h203, 0, 32'h80FF1234, 0, 1);
    check("lb_data", rdo, 32'hFFFFFF80);
    run(1, 0, F3_BU, 32'h203, 0, 32'h80FF1234, 0, 0);
    check("lbu_data", rdo, 32'h00000080);

    clr_counts();
    run(0, 1, F3_H, 32'h302, 32'h0000ABCD, 0, 0, 3);
    check("sh_stalls", n_stall, 5);
    check("sh_we", last_we, 1);
    check("sh_be", last_be, 4'b1100);
    check("sh_wdata", last_wdata, 32'hABCDABCD);
    check("sh_keep", rdo, 32'h00000080);

    clr_counts();
    run(1, 0, F3_W, 32'h101, 0, 0, 0, 0);
    check("mis_faults", n_fault, 1);
    check("mis_cause", last_cause, 2'b01);
    check("mis_stalls", n_stall, 0);
    check("mis_reqs", n_req, 0);
    clr_counts();
    run(1, 1, F3_W, 32'h100, 0, 0, 0, 0);
    check("ill_cause", last_cause, 2'b11);
    check("ill_reqs", n_req, 0);

    clr_counts();
    run(1, 0, F3_W, 32'h400, 0, 32'h12345678, 1, 1);
    check("err_faults", n_fault, 1);
    check("err_cause", last_cause, 2'b10);
    check("err_keep", rdo, 32'h00000080);

    mem_rd = 1'b1;
    mem_wr = 1'b0;
    f3     = F3_W;
    addr   = 32'h500;
    set_exp(1'b1, 1'b0, 2'd0, 1'b0);
    bus_if.bus_ack = 1'b0;
    @(posedge clk) #1;
    e_valid = 1'b0;
    check("pre_rst_req", bus_if.bus_req, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_req", bus_if.bus_req, 0);
    check("arst_stall", stall, 0);
    check("arst_wbs", wbs, 0);
    check("arst_rdata", rdo, 0);
    check("arst_addr", bus_if.bus_addr, 0);
    check("arst_we", bus_if.bus_we, 0);
    check("arst_wdata", bus_if.bus_wdata, 0);
    @(posedge clk) #1;
    rst  = 1'b1;
    m_rd = '0;
    run(0, 0, 0, 0, 0, 0, 0, 0);
    e_valid = 1'b1;
    run(0, 0, 0, 0, 0, 0, 0, 0);
    clr_counts();
    run(1, 0, F3_W, 32'h600, 0, 32'hCAFEF00D, 0, 0);
    check("post_rst_stalls", n_stall, 2);
    check("post_rst_data", rdo, 32'hCAFEF00D);

    for (int k = 0; k < 400; k++) begin
      r  = int'($urandom % 8);
      rd = (r >= 1 && r <= 4) || r == 7;
      wr = (r >= 5);
      if ($urandom % 4 != 0)
        f = wr ? 3'($urandom % 3)
               : 3'(((($urandom % 5) + 3) % 6) ^ 3'd0);
      else
        f = 3'($urandom);
      a = $urandom;
      if ($urandom % 2 == 0) a[1:0] = 2'b00;
      er = ($urandom % 8) == 0;
      run(rd, wr, f, a, $urandom, $urandom, er,
          int'($urandom % 4));
    end

    e_valid = 1'b0;
    @(posedge clk) #1;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
